// File: rtl/bullet_sequencer.sv
// ---------------------------------------------------------------------------
// bullet_sequencer
//   Owns the single player bullet: launches it at the player's X on a fire
//   request, steps it upward once per frame, and retires it on a top-edge
//   miss or a mapper collision. A cooldown of COOLDOWN_FRAMES frames follows
//   every retire. Hits are reported as a pulse and as a saturating count.
//
//   Build option BULLET_AUTOFIRE_EN:
//     defined     -> fire is used as a level (holding it keeps shooting)
//     not defined -> only a rising edge of fire requests a shot
// ---------------------------------------------------------------------------
module bullet_sequencer #(
  parameter int unsigned BULLET_SPEED    = 4,
  parameter int unsigned BULLET_LEN      = 4,
  parameter int unsigned PLAYER_Y        = 440,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic       fire,
  input  logic [9:0] playerX,
  input  logic       collision,
  output logic       bullet_in,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic       fire_ack,
  output logic       hit_pulse,
  output logic [7:0] hit_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLIGHT,
    S_RETIRE,
    S_COOLDOWN
  } state_e;

  localparam int unsigned     CD_W     = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [9:0]      LAUNCH_Y = 10'(PLAYER_Y - BULLET_LEN);
  localparam logic [9:0]      STEP_Y   = 10'(BULLET_SPEED);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE   = CD_W'(1);
  localparam logic [7:0]      HIT_MAX  = 8'hFF;

  state_e          state_q, state_d;
  logic [9:0]      bullet_x_q, bullet_x_d;
  logic [9:0]      bullet_y_q, bullet_y_d;
  logic            bullet_in_q, bullet_in_d;
  logic            hit_latch_q, hit_latch_d;
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
  logic [7:0]      hit_count_q, hit_count_d;
  logic            fire_ack_q, fire_ack_d;
  logic            hit_pulse_q, hit_pulse_d;
  logic            ga_prev_q, ga_prev_d;

  logic            fire_req;
  logic            ga_rise;
  logic            hit_now;

`ifdef BULLET_AUTOFIRE_EN
  // Level-sensitive request: a held button relaunches whenever IDLE is reached.
  assign fire_req = fire;
`else
  logic fire_prev_q, fire_prev_d;

  // Previous fire level, so only a fresh press makes a request.
  always_comb begin
    fire_prev_d = fire;
  end

  // Fire edge register; it tracks every cycle, so edges seen outside IDLE are lost.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fire_prev_q <= 1'b0;
    else          fire_prev_q <= fire_prev_d;
  end

  assign fire_req = fire & ~fire_prev_q;
`endif

  assign ga_rise = game_active & ~ga_prev_q;

  // A collision in the same cycle as the frame tick still counts as a hit.
  assign hit_now = hit_latch_q | collision;

  // Next-state and datapath decisions for the bullet life cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    bullet_x_d  = bullet_x_q;
    bullet_y_d  = bullet_y_q;
    hit_latch_d = hit_latch_q;
    cd_cnt_d    = cd_cnt_q;
    hit_count_d = hit_count_q;
    fire_ack_d  = 1'b0;
    hit_pulse_d = 1'b0;
    ga_prev_d   = game_active;

    if (!game_active) begin
      // Leaving the game: drop the bullet silently, keep the score for display.
      state_d  = S_IDLE;
      cd_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fire_req) begin
            state_d     = S_LAUNCH;
            bullet_x_d  = playerX;
            bullet_y_d  = LAUNCH_Y;
            hit_latch_d = 1'b0;
            fire_ack_d  = 1'b1;
          end
        end

        S_LAUNCH: begin
          state_d = S_FLIGHT;
        end

        S_FLIGHT: begin
          hit_latch_d = hit_now;
          if (frame_tick) begin
            if (hit_now) begin
              state_d     = S_RETIRE;
              hit_pulse_d = 1'b1;
              if (hit_count_q != HIT_MAX) hit_count_d = hit_count_q + 8'd1;
            end else if (bullet_y_q < STEP_Y) begin
              // Checked before subtracting so Y never wraps past the top.
              state_d = S_RETIRE;
            end else begin
              bullet_y_d = bullet_y_q - STEP_Y;
            end
          end
        end

        S_RETIRE: begin
          cd_cnt_d = CD_LOAD;
          state_d  = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
        end

        S_COOLDOWN: begin
          if (frame_tick) begin
            cd_cnt_d = cd_cnt_q - CD_ONE;
            if (cd_cnt_q == CD_ONE) state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // A new game starts with a clean score.
      if (ga_rise) hit_count_d = '0;
    end

    bullet_in_d = (state_d == S_FLIGHT);
  end

  // State and datapath registers; reset makes the bullet vanish at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      bullet_x_q  <= '0;
      bullet_y_q  <= '0;
      bullet_in_q <= 1'b0;
      hit_latch_q <= 1'b0;
      cd_cnt_q    <= '0;
      hit_count_q <= '0;
      fire_ack_q  <= 1'b0;
      hit_pulse_q <= 1'b0;
      ga_prev_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the values
      // computed from the previous cycle, independent of statement order.
      state_q     <= state_d;
      bullet_x_q  <= bullet_x_d;
      bullet_y_q  <= bullet_y_d;
      bullet_in_q <= bullet_in_d;
      hit_latch_q <= hit_latch_d;
      cd_cnt_q    <= cd_cnt_d;
      hit_count_q <= hit_count_d;
      fire_ack_q  <= fire_ack_d;
      hit_pulse_q <= hit_pulse_d;
      ga_prev_q   <= ga_prev_d;
    end
  end

  assign bullet_in = bullet_in_q;
  assign bulletX   = bullet_x_q;
  assign bulletY   = bullet_y_q;
  assign fire_ack  = fire_ack_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_bullet_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bullet_sequencer
//   Directed bench for bullet_sequencer with default parameters. Frames are
//   four clocks long (tick on the first). Inputs change and outputs are read
//   1 time unit after each rising edge. Expectations for held fire depend on
//   whether BULLET_AUTOFIRE_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_bullet_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       game_active;
  logic       fire;
  logic [9:0] playerX;
  logic       collision;
  logic       bullet_in;
  logic [9:0] bulletX;
  logic [9:0] bulletY;
  logic       fire_ack;
  logic       hit_pulse;
  logic [7:0] hit_count;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;
  int hit_cnt  = 0;
  int overlap  = 0;

  bullet_sequencer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .game_active (game_active),
    .fire        (fire),
    .playerX     (playerX),
    .collision   (collision),
    .bullet_in   (bullet_in),
    .bulletX     (bulletX),
    .bulletY     (bulletY),
    .fire_ack    (fire_ack),
    .hit_pulse   (hit_pulse),
    .hit_count   (hit_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Pulse counters sampled on the falling edge, away from register updates.
  always @(negedge Clk) begin
    if (fire_ack) ack_cnt++;
    if (hit_pulse) hit_cnt++;
    if (fire_ack && hit_pulse) overlap++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(3);
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    Reset_n     = 1'b0;
    frame_tick  = 1'b0;
    game_active = 1'b0;
    fire        = 1'b0;
    playerX     = '0;
    collision   = 1'b0;
    cyc(3);
    n_checks++;
    if ({bullet_in, bulletX, bulletY, fire_ack, hit_pulse, hit_count} !== 31'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bullet_in, bulletX, bulletY, fire_ack, hit_pulse, hit_count});
    end
    Reset_n = 1'b1;
    cyc(1);
    for (int f = 0; f < 3; f++) begin
      frame();
      n_checks++;
      if (bullet_in !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_bullet_in frame %0d: got %b expected 0", f, bullet_in);
      end
    end
    n_checks++;
    if ({bulletX, bulletY, hit_count} !== 28'd0 || ack_cnt !== 0 || hit_cnt !== 0) begin
      n_errors++;
      $display("FAIL idle_quiet: x=%0d y=%0d hits=%0d acks=%0d pulses=%0d expected all 0",
               bulletX, bulletY, hit_count, ack_cnt, hit_cnt);
    end
  endtask

  task automatic test_launch();
    game_active = 1'b1;
    playerX     = 10'd320;
    cyc(1);
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    n_checks++;
    if ({fire_ack, bullet_in} !== 2'b10) begin
      n_errors++;
      $display("FAIL launch_ack: got ack=%b in=%b expected ack=1 in=0", fire_ack, bullet_in);
    end
    n_checks++;
    if (bulletX !== 10'd320 || bulletY !== 10'd436) begin
      n_errors++;
      $display("FAIL launch_pos: got x=%0d y=%0d expected x=320 y=436", bulletX, bulletY);
    end
    cyc(1);
    n_checks++;
    if ({fire_ack, bullet_in} !== 2'b01) begin
      n_errors++;
      $display("FAIL launch_visible: got ack=%b in=%b expected ack=0 in=1", fire_ack, bullet_in);
    end
    repeat (3) frame();
    n_checks++;
    if (bulletY !== 10'd424) begin
      n_errors++;
      $display("FAIL step_3_frames: got y=%0d expected 424", bulletY);
    end
  endtask

  task automatic test_miss();
    int h0;
    int a0;
    repeat (106) frame();
    n_checks++;
    if (bulletY !== 10'd0 || bullet_in !== 1'b1) begin
      n_errors++;
      $display("FAIL top_row: got y=%0d in=%b expected y=0 in=1", bulletY, bullet_in);
    end
    h0 = hit_cnt;
    frame();
    n_checks++;
    if (bullet_in !== 1'b0 || bulletY !== 10'd0 || hit_cnt !== h0 || hit_count !== 8'd0) begin
      n_errors++;
      $display("FAIL miss_retire: got in=%b y=%0d pulses=%0d count=%0d expected in=0 y=0 pulses=%0d count=0",
               bullet_in, bulletY, hit_cnt, hit_count, h0);
    end
    repeat (7) frame();
    a0 = ack_cnt;
    fire_pulse();
    n_checks++;
    if (ack_cnt !== a0) begin
      n_errors++;
      $display("FAIL cooldown_blocks_fire: got acks=%0d expected %0d", ack_cnt, a0);
    end
    frame();
    playerX = 10'd100;
    fire_pulse();
    n_checks++;
    if (ack_cnt !== a0 + 1 || bullet_in !== 1'b1) begin
      n_errors++;
      $display("FAIL cooldown_end_fire: got acks=%0d in=%b expected acks=%0d in=1",
               ack_cnt, bullet_in, a0 + 1);
    end
    n_checks++;
    if (bulletX !== 10'd100 || bulletY !== 10'd436) begin
      n_errors++;
      $display("FAIL relaunch_pos: got x=%0d y=%0d expected x=100 y=436", bulletX, bulletY);
    end
  endtask

  task automatic test_hit();
    int h0;
    frame();
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    n_checks++;
    if (bullet_in !== 1'b1) begin
      n_errors++;
      $display("FAIL hit_waits_for_tick: got in=%b expected 1", bullet_in);
    end
    h0 = hit_cnt;
    frame();
    n_checks++;
    if (bullet_in !== 1'b0 || bulletY !== 10'd432 || hit_cnt !== h0 + 1 || hit_count !== 8'd1) begin
      n_errors++;
      $display("FAIL latched_hit: got in=%b y=%0d pulses=%0d count=%0d expected in=0 y=432 pulses=%0d count=1",
               bullet_in, bulletY, hit_cnt, hit_count, h0 + 1);
    end
    repeat (8) frame();
    playerX = 10'd200;
    fire_pulse();
    n_checks++;
    if (bullet_in !== 1'b1 || bulletX !== 10'd200) begin
      n_errors++;
      $display("FAIL hit_relaunch: got in=%b x=%0d expected in=1 x=200", bullet_in, bulletX);
    end
    collision  = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    collision  = 1'b0;
    frame_tick = 1'b0;
    n_checks++;
    if (bullet_in !== 1'b0 || bulletY !== 10'd436) begin
      n_errors++;
      $display("FAIL same_cycle_hit: got in=%b y=%0d expected in=0 y=436", bullet_in, bulletY);
    end
    cyc(3);
    n_checks++;
    if (hit_count !== 8'd2 || hit_cnt !== h0 + 2) begin
      n_errors++;
      $display("FAIL hit_count_2: got count=%0d pulses=%0d expected count=2 pulses=%0d",
               hit_count, hit_cnt, h0 + 2);
    end
    repeat (8) frame();
  endtask

  task automatic test_abort();
    int h0;
    int a0;
    fire_pulse();
    frame();
    frame();
    h0 = hit_cnt;
    collision = 1'b1;
    cyc(1);
    collision   = 1'b0;
    game_active = 1'b0;
    frame_tick  = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    n_checks++;
    if (bullet_in !== 1'b0 || bulletY !== 10'd428) begin
      n_errors++;
      $display("FAIL abort_vanish: got in=%b y=%0d expected in=0 y=428", bullet_in, bulletY);
    end
    cyc(4);
    n_checks++;
    if (hit_cnt !== h0 || hit_count !== 8'd2) begin
      n_errors++;
      $display("FAIL abort_no_hit: got pulses=%0d count=%0d expected pulses=%0d count=2",
               hit_cnt, hit_count, h0);
    end
    a0 = ack_cnt;
    fire_pulse();
    n_checks++;
    if (ack_cnt !== a0) begin
      n_errors++;
      $display("FAIL inactive_fire: got acks=%0d expected %0d", ack_cnt, a0);
    end
    game_active = 1'b1;
    cyc(1);
    n_checks++;
    if (hit_count !== 8'd0) begin
      n_errors++;
      $display("FAIL new_game_clear: got count=%0d expected 0", hit_count);
    end
    // Abort during cooldown, then fire straight away in the new game.
    fire_pulse();
    collision  = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    collision  = 1'b0;
    frame_tick = 1'b0;
    cyc(2);
    game_active = 1'b0;
    cyc(1);
    game_active = 1'b1;
    cyc(1);
    a0 = ack_cnt;
    fire_pulse();
    n_checks++;
    if (ack_cnt !== a0 + 1 || bullet_in !== 1'b1 || hit_count !== 8'd0) begin
      n_errors++;
      $display("FAIL cooldown_cleared: got acks=%0d in=%b count=%0d expected acks=%0d in=1 count=0",
               ack_cnt, bullet_in, hit_count, a0 + 1);
    end
  endtask

  task automatic test_hold_fire();
    int a0;
    game_active = 1'b0;
    cyc(1);
    game_active = 1'b1;
    cyc(1);
    a0   = ack_cnt;
    fire = 1'b1;
    repeat (40) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      collision  = 1'b1;
      cyc(1);
      collision = 1'b0;
      cyc(2);
    end
    fire = 1'b0;
    cyc(2);
`ifdef BULLET_AUTOFIRE_EN
    n_checks++;
    if (ack_cnt - a0 < 2) begin
      n_errors++;
      $display("FAIL autofire_repeat: got %0d acks expected at least 2", ack_cnt - a0);
    end
`else
    n_checks++;
    if (ack_cnt - a0 !== 1 || hit_count !== 8'd1) begin
      n_errors++;
      $display("FAIL held_single_shot: got acks=%0d count=%0d expected acks=1 count=1",
               ack_cnt - a0, hit_count);
    end
`endif
  endtask

  task automatic one_hit();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
    collision  = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    collision  = 1'b0;
    frame_tick = 1'b0;
    cyc(1);
    frame_tick = 1'b1;
    cyc(8);
    frame_tick = 1'b0;
  endtask

  task automatic test_saturate();
    int h0;
    game_active = 1'b0;
    cyc(1);
    game_active = 1'b1;
    cyc(1);
    one_hit();
    n_checks++;
    if (hit_count !== 8'd1) begin
      n_errors++;
      $display("FAIL sat_first: got count=%0d expected 1", hit_count);
    end
    repeat (254) one_hit();
    n_checks++;
    if (hit_count !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_reach: got count=%0d expected 255", hit_count);
    end
    h0 = hit_cnt;
    one_hit();
    n_checks++;
    if (hit_count !== 8'd255 || hit_cnt !== h0 + 1) begin
      n_errors++;
      $display("FAIL sat_hold: got count=%0d pulses=%0d expected count=255 pulses=%0d",
               hit_count, hit_cnt, h0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_miss();
    test_hit();
    test_abort();
    test_hold_fire();
    test_saturate();
    n_checks++;
    if (overlap !== 0) begin
      n_errors++;
      $display("FAIL ack_hit_overlap: got %0d coincident cycles expected 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
